instr_rom_seq: RTL and testbench

Parametrised, synchronous instruction memory for the 16-bit ThinPad CPU fetch stage. It returns the instruction at the requested PC with one-cycle registered latency. While a data-memory conflict steals the bus, it inserts NOPs and then replays the displaced fetch. A side-band load port fills the program store before or during execution, and a saturating counter records how many cycles were lost to conflicts.

---
 rtl/instr_rom_seq_if.sv | 29 ++
 rtl/instr_rom_seq.sv | 142 ++++++++++++++
 tb/tb_instr_rom_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_rom_seq_if.sv
// Fetch-side bus of the instruction ROM: the PC and conflict inputs from the CPU,
// the program-load side band, and the registered fetch results.
// The master modport is the CPU/loader side. The slave modport is the ROM.
// Width parameters must match those of the attached instr_rom_seq instance.
interface instr_rom_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    logic [15:0]       pc;
    logic              mem_conflict;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] instruction;
    logic              valid;
    logic              oor;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output pc, mem_conflict, load_en, load_addr, load_data,
        input  instruction, valid, oor, conflict_cnt
    );

    modport slave (
        input  pc, mem_conflict, load_en, load_addr, load_data,
        output instruction, valid, oor, conflict_cnt
    );
endinterface

// File: rtl/instr_rom_seq.sv
// Instruction memory for the ThinPad fetch stage.
// - Fetches are registered, so the result appears one cycle after the PC is presented.
// - While mem_conflict holds, the ROM emits NOP_WORD and keeps the displaced PC.
// - It replays the kept PC on the first cycle after the conflict ends.
// - A side-band port writes the program store.
// - A saturating counter tracks cycles lost to conflicts.
// Optional feature, macro IMEM_OOR_TRAP_EN: a PC >= DEPTH traps to NOP_WORD with
// oor=1 and does not wrap. Without the macro, the upper PC bits are ignored and
// oor is tied 0.
module instr_rom_seq #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'b0000100000000000,
    parameter int                CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_rom_seq_if.slave       bus
);
    localparam int DEPTH = 2 ** ADDR_W;

`ifdef IMEM_OOR_TRAP_EN
    // The trap needs the full PC, including bits above the index, when it replays.
    localparam int HELD_W = 16;
`else
    localparam int HELD_W = ADDR_W;
`endif

    typedef enum logic {RUN, HOLD} state_t;

    state_t state, state_d;

    // NOTE: the program store has no reset. The loader owns its contents, and rst
    // must not erase a program that was loaded before reset was applied.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    logic [HELD_W-1:0] held_pc, held_pc_d;
    logic [HELD_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q;

    // A replay uses the kept PC. Any other fetch uses the live PC.
    assign fetch_pc = (state == HOLD) ? held_pc : bus.pc[HELD_W-1:0];
    assign idx      = fetch_pc[ADDR_W-1:0];

`ifdef IMEM_OOR_TRAP_EN
    logic oor_q, oor_d;
    logic out_of_range;
    assign out_of_range = |fetch_pc[15:ADDR_W];
`else
    logic unused_pc_hi;
    assign unused_pc_hi = ^bus.pc[15:ADDR_W];
`endif

    // Program load. The read in the output logic sees the pre-edge word, so a
    // fetch or replay at the index being written returns the old contents.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // State register and registered fetch outputs.
    // NOTE: every sequential assignment uses <= so that all registers update from
    // the same pre-edge values. A blocking assignment here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            held_pc <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
`ifdef IMEM_OOR_TRAP_EN
            oor_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            held_pc <= held_pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef IMEM_OOR_TRAP_EN
            oor_q   <= oor_d;
`endif
        end
    end

    // Saturating count of cycles where the data side owned the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.mem_conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Next state: a conflict holds the fetch, and its release returns to RUN via a replay.
    always_comb begin
        state_d = bus.mem_conflict ? HOLD : RUN;
    end

    // Next outputs: NOP while displaced; otherwise a fetch of the live PC or the replayed PC.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        instr_d   = NOP_WORD;
        valid_d   = 1'b0;
        held_pc_d = held_pc;
`ifdef IMEM_OOR_TRAP_EN
        oor_d     = oor_q;
`endif
        if (bus.mem_conflict) begin
            // Only the first conflict cycle captures the PC. Later ones ignore pc.
            if (state == RUN) begin
                held_pc_d = bus.pc[HELD_W-1:0];
            end
        end else begin
`ifdef IMEM_OOR_TRAP_EN
            if (out_of_range) begin
                oor_d = 1'b1;
            end else begin
                instr_d = mem[idx];
                valid_d = 1'b1;
                oor_d   = 1'b0;
            end
`else
            instr_d = mem[idx];
            valid_d = 1'b1;
`endif
        end
    end

    assign bus.instruction  = instr_q;
    assign bus.valid        = valid_q;
    assign bus.conflict_cnt = cnt_q;
`ifdef IMEM_OOR_TRAP_EN
    assign bus.oor          = oor_q;
`else
    assign bus.oor          = 1'b0;
`endif

endmodule

// File: tb/tb_instr_rom_seq.sv
// Testbench for instr_rom_seq.
// - The main instance (DEPTH 16, 8-bit counter) is checked every cycle against a
//   behavioural model: a word array, a pending-replay flag, and a counter clipped at 255.
// - A small instance (ADDR_W=2, CNT_W=2) shares the stimulus and pins the
//   saturation and range corner cases with literal values.
// - Directed phases are followed by randomized traffic.
module tb_instr_rom_seq;
    localparam logic [15:0] NOP = 16'h0800;

    logic clk;
    logic rst;

    instr_rom_seq_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(8)) bif ();
    instr_rom_seq_if #(.DATA_W(16), .ADDR_W(2), .CNT_W(2)) sif ();

    instr_rom_seq #(.DATA_W(16), .ADDR_W(4), .NOP_WORD(NOP), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    instr_rom_seq #(.DATA_W(16), .ADDR_W(2), .NOP_WORD(NOP), .CNT_W(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    assign sif.pc           = bif.pc;
    assign sif.mem_conflict = bif.mem_conflict;
    assign sif.load_en      = bif.load_en;
    assign sif.load_addr    = bif.load_addr[1:0];
    assign sif.load_data    = bif.load_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the main instance.
    logic [15:0] model_mem [16];
    logic [15:0] exp_instr;
    logic        exp_valid;
    logic        exp_oor;
    int          exp_cnt;
    bit          pending;
    logic [15:0] pend_pc;

    initial begin
        foreach (model_mem[i]) model_mem[i] = NOP;
        exp_instr = NOP;
        exp_valid = 1'b0;
        exp_oor   = 1'b0;
        exp_cnt   = 0;
        pending   = 1'b0;
        pend_pc   = '0;
    end

    task automatic model_fetch(input logic [15:0] a);
`ifdef IMEM_OOR_TRAP_EN
        if (a >= 16'd16) begin
            exp_instr = NOP;
            exp_valid = 1'b0;
            exp_oor   = 1'b1;
            return;
        end
        exp_oor = 1'b0;
`endif
        exp_instr = model_mem[a % 16];
        exp_valid = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_instr = NOP;
            exp_valid = 1'b0;
            exp_oor   = 1'b0;
            exp_cnt   = 0;
            pending   = 1'b0;
        end else if (bif.mem_conflict) begin
            exp_instr = NOP;
            exp_valid = 1'b0;
            if (!pending) begin
                pending = 1'b1;
                pend_pc = bif.pc;
            end
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        end else begin
            model_fetch(pending ? pend_pc : bif.pc);
            pending = 1'b0;
        end
        // The load lands after the read, so a same-edge fetch sees the old word.
        if (bif.load_en) model_mem[bif.load_addr] = bif.load_data;
    end

    // Per-cycle compare of the main instance, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        check("model_instruction", 32'(bif.instruction), 32'(exp_instr));
        check("model_valid", 32'(bif.valid), 32'(exp_valid));
        check("model_oor", 32'(bif.oor), 32'(exp_oor));
        check("model_cnt", 32'(bif.conflict_cnt), 32'(exp_cnt));
    end

    task automatic drive(input logic [15:0] p, input logic c, input logic le,
                         input logic [3:0] la, input logic [15:0] ld);
        @(negedge clk);
        bif.pc           = p;
        bif.mem_conflict = c;
        bif.load_en      = le;
        bif.load_addr    = la;
        bif.load_data    = ld;
    endtask

    logic [15:0] prog [4];
    logic [1:0]  sat_seq [6];

    initial begin
        prog[0] = 16'h4801; prog[1] = 16'h4901; prog[2] = 16'hE82C; prog[3] = 16'hEA0F;
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3; sat_seq[4] = 2'd3; sat_seq[5] = 2'd3;

        rst              = 1'b0;
        bif.pc           = '0;
        bif.mem_conflict = 1'b0;
        bif.load_en      = 1'b0;
        bif.load_addr    = '0;
        bif.load_data    = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_instruction", 32'(bif.instruction), 32'h0800);
        check("reset_valid", 32'(bif.valid), 32'd0);
        check("reset_cnt", 32'(bif.conflict_cnt), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Saturation on the 2-bit counter.
        for (int i = 0; i < 6; i++) begin
            drive(16'd0, 1'b1, 1'b0, 4'd0, 16'd0);
            @(posedge clk); #1;
            check("small_sat_cnt", 32'(sif.conflict_cnt), 32'(sat_seq[i]));
        end
        drive(16'd0, 1'b0, 1'b0, 4'd0, 16'd0);

        // Load the program and fetch it back.
        for (int i = 0; i < 4; i++) drive(16'd0, 1'b0, 1'b1, 4'(i), prog[i]);
        for (int i = 0; i < 4; i++) begin
            drive(16'(i), 1'b0, 1'b0, 4'd0, 16'd0);
            @(posedge clk); #1;
            check("basic_fetch", 32'(bif.instruction), 32'(prog[i]));
            check("basic_valid", 32'(bif.valid), 32'd1);
        end

        // Out-of-range PC on the 4-word instance.
        drive(16'd6, 1'b0, 1'b0, 4'd0, 16'd0);
        @(posedge clk); #1;
`ifdef IMEM_OOR_TRAP_EN
        check("range_instruction", 32'(sif.instruction), 32'h0800);
        check("range_valid", 32'(sif.valid), 32'd0);
        check("range_oor", 32'(sif.oor), 32'd1);
`else
        check("range_instruction", 32'(sif.instruction), 32'hE82C);
        check("range_valid", 32'(sif.valid), 32'd1);
        check("range_oor", 32'(sif.oor), 32'd0);
`endif

        // Conflict for three cycles on pc=2, then the replay, then a normal fetch.
        drive(16'd2, 1'b1, 1'b0, 4'd0, 16'd0);
        @(posedge clk); #1;
        check("conflict_nop", 32'(bif.instruction), 32'h0800);
        check("conflict_valid", 32'(bif.valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(16'd3, 1'b1, 1'b0, 4'd0, 16'd0);
            @(posedge clk); #1;
            check("conflict_nop", 32'(bif.instruction), 32'h0800);
            check("conflict_valid", 32'(bif.valid), 32'd0);
        end
        drive(16'd3, 1'b0, 1'b0, 4'd0, 16'd0);
        @(posedge clk); #1;
        check("replay_word", 32'(bif.instruction), 32'hE82C);
        check("replay_valid", 32'(bif.valid), 32'd1);
        check("conflict_cnt", 32'(bif.conflict_cnt), 32'd9);
        drive(16'd3, 1'b0, 1'b0, 4'd0, 16'd0);
        @(posedge clk); #1;
        check("resume_fetch", 32'(bif.instruction), 32'hEA0F);

        // Read during write at index 5.
        drive(16'd0, 1'b0, 1'b1, 4'd5, 16'h1111);
        drive(16'd5, 1'b0, 1'b1, 4'd5, 16'h2222);
        @(posedge clk); #1;
        check("rdw_old", 32'(bif.instruction), 32'h1111);
        drive(16'd5, 1'b0, 1'b0, 4'd0, 16'd0);
        @(posedge clk); #1;
        check("rdw_new", 32'(bif.instruction), 32'h2222);

        // Reset while in HOLD with held_pc=1. The replay must not survive the reset.
        drive(16'd1, 1'b1, 1'b0, 4'd0, 16'd0);
        @(negedge clk) rst = 1'b1;
        #1;
        check("async_rst_instruction", 32'(bif.instruction), 32'h0800);
        check("async_rst_valid", 32'(bif.valid), 32'd0);
        check("async_rst_cnt", 32'(bif.conflict_cnt), 32'd0);
        @(negedge clk);
        rst              = 1'b0;
        bif.mem_conflict = 1'b0;
        bif.pc           = 16'd3;
        @(posedge clk); #1;
        check("post_rst_fetch", 32'(bif.instruction), 32'hEA0F);

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst              = ($urandom_range(0, 99) == 0);
            bif.pc           = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            bif.mem_conflict = ($urandom_range(0, 9) < 3);
            bif.load_en      = ($urandom_range(0, 4) == 0);
            bif.load_addr    = 4'($urandom);
            bif.load_data    = 16'($urandom);
        end
        @(negedge clk) rst = 1'b0;

        // Long conflict burst to drive the 8-bit counter into saturation.
        for (int i = 0; i < 300; i++) drive(16'($urandom), 1'b1, 1'b0, 4'd0, 16'd0);
        @(posedge clk); #1;
        check("cnt_saturated", 32'(bif.conflict_cnt), 32'd255);
        drive(16'd0, 1'b0, 1'b0, 4'd0, 16'd0);
        repeat (3) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
